// File: rtl/dual_core_bus_arbiter.sv
// Round-robin owner arbiter muxing two cores onto one external bus, with a one-cycle idle turnaround between owners.
// Optional watchdog forced release is compiled in with ARB_WATCHDOG_EN.
module dual_core_bus_arbiter #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_lock0,
  input  logic              i_lock1,
  input  logic              i_done0,
  input  logic              i_done1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  input  logic [DATA_W-1:0] i_data_out0,
  input  logic [DATA_W-1:0] i_data_out1,
  input  logic              i_enb0,
  input  logic              i_enb1,
  input  logic              i_nme0,
  input  logic              i_nale0,
  input  logic              i_rnw0,
  input  logic              i_noe0,
  input  logic              i_nme1,
  input  logic              i_nale1,
  input  logic              i_rnw1,
  input  logic              i_noe1,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_enb,
  output logic              o_nme,
  output logic              o_nale,
  output logic              o_rnw,
  output logic              o_noe,
  output logic              o_owner,
  output logic              o_busy,
  output logic              o_timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dual_core_bus_arbiter: TIMEOUT must be 1..255");
  end

  state_t r_state;
  logic   r_gnt0;
  logic   r_gnt1;
  logic   r_owner;
  logic   r_busy;
  state_t w_arb;
  logic   w_rel0;
  logic   w_rel1;
  logic   w_force0;
  logic   w_force1;

  // Tie goes to the core that did not own the bus last.
  always_comb begin
    w_arb = IDLE;
    if (i_req0 && !i_req1)
      w_arb = OWN0;
    else if (!i_req0 && i_req1)
      w_arb = OWN1;
    else if (i_req0 && i_req1)
      w_arb = r_owner ? OWN0 : OWN1;
  end

  assign w_rel0 = (i_done0 & ~i_lock0) | ~i_req0;
  assign w_rel1 = (i_done1 & ~i_lock1) | ~i_req1;

`ifdef ARB_WATCHDOG_EN
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic       w_cnt_last;

  assign w_cnt_last = (r_cnt == LP_CNT_LAST);
  assign w_force0   = w_cnt_last & i_req1;
  assign w_force1   = w_cnt_last & i_req0;
  assign o_timeout  = r_timeout;
`else
  assign w_force0   = 1'b0;
  assign w_force1   = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_owner <= 1'b1;
      r_busy  <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_WATCHDOG_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE, TURN: begin
          r_state <= w_arb;
          r_gnt0  <= (w_arb == OWN0);
          r_gnt1  <= (w_arb == OWN1);
          r_busy  <= (w_arb != IDLE);
          if (w_arb == OWN0)
            r_owner <= 1'b0;
          else if (w_arb == OWN1)
            r_owner <= 1'b1;
`ifdef ARB_WATCHDOG_EN
          r_cnt <= 8'd0;
`endif
        end
        OWN0: begin
          if (w_rel0 || w_force0) begin
            r_state <= TURN;
            r_gnt0  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            r_timeout <= w_force0 & ~w_rel0;
          end else if (!w_cnt_last) begin
            r_cnt <= r_cnt + 8'd1;
`endif
          end
        end
        OWN1: begin
          if (w_rel1 || w_force1) begin
            r_state <= TURN;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            r_timeout <= w_force1 & ~w_rel1;
          end else if (!w_cnt_last) begin
            r_cnt <= r_cnt + 8'd1;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt0  = r_gnt0;
  assign o_gnt1  = r_gnt1;
  assign o_owner = r_owner;
  assign o_busy  = r_busy;

  // Only the registered owner state selects a core; every other state parks the bus idle.
  always_comb begin
    o_data_out = '0;
    o_enb      = 1'b1;
    o_nme      = 1'b1;
    o_nale     = 1'b1;
    o_rnw      = 1'b1;
    o_noe      = 1'b1;
    case (r_state)
      OWN0: begin
        o_data_out = i_data_out0;
        o_enb      = i_enb0;
        o_nme      = i_nme0;
        o_nale     = i_nale0;
        o_rnw      = i_rnw0;
        o_noe      = i_noe0;
      end
      OWN1: begin
        o_data_out = i_data_out1;
        o_enb      = i_enb1;
        o_nme      = i_nme1;
        o_nale     = i_nale1;
        o_rnw      = i_rnw1;
        o_noe      = i_noe1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dual_core_bus_arbiter.sv
// Directed bench for dual_core_bus_arbiter; the second instance (TIMEOUT=4) exercises the watchdog when ARB_WATCHDOG_EN is set.
module tb_dual_core_bus_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, lock0, lock1, done0, done1;
  logic [DW-1:0] data0, data1;
  logic          enb0, enb1, nme0, nale0, rnw0, noe0, nme1, nale1, rnw1, noe1;

  logic          gnt0, gnt1, enb, nme, nale, rnw, noe, owner, busy, tmo;
  logic [DW-1:0] data;
  logic          gnt0_b, gnt1_b, enb_b, nme_b, nale_b, rnw_b, noe_b, owner_b, busy_b, tmo_b;
  logic [DW-1:0] data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_held;
  logic tmo_seen;

  always #5 clk = ~clk;

  dual_core_bus_arbiter #(.DATA_W(DW), .TIMEOUT(255)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
    .i_done0(done0), .i_done1(done1), .o_gnt0(gnt0), .o_gnt1(gnt1),
    .i_data_out0(data0), .i_data_out1(data1), .i_enb0(enb0), .i_enb1(enb1),
    .i_nme0(nme0), .i_nale0(nale0), .i_rnw0(rnw0), .i_noe0(noe0),
    .i_nme1(nme1), .i_nale1(nale1), .i_rnw1(rnw1), .i_noe1(noe1),
    .o_data_out(data), .o_enb(enb), .o_nme(nme), .o_nale(nale), .o_rnw(rnw), .o_noe(noe),
    .o_owner(owner), .o_busy(busy), .o_timeout(tmo)
  );

  dual_core_bus_arbiter #(.DATA_W(DW), .TIMEOUT(4)) dut_wd (
    .i_clock(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
    .i_done0(done0), .i_done1(done1), .o_gnt0(gnt0_b), .o_gnt1(gnt1_b),
    .i_data_out0(data0), .i_data_out1(data1), .i_enb0(enb0), .i_enb1(enb1),
    .i_nme0(nme0), .i_nale0(nale0), .i_rnw0(rnw0), .i_noe0(noe0),
    .i_nme1(nme1), .i_nale1(nale1), .i_rnw1(rnw1), .i_noe1(noe1),
    .o_data_out(data_b), .o_enb(enb_b), .o_nme(nme_b), .o_nale(nale_b), .o_rnw(rnw_b), .o_noe(noe_b),
    .o_owner(owner_b), .o_busy(busy_b), .o_timeout(tmo_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_enb"},  {63'd0, enb},  64'd1);
    chk({tag, "_nme"},  {63'd0, nme},  64'd1);
    chk({tag, "_nale"}, {63'd0, nale}, 64'd1);
    chk({tag, "_rnw"},  {63'd0, rnw},  64'd1);
    chk({tag, "_noe"},  {63'd0, noe},  64'd1);
    chk({tag, "_data"}, data,          64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; done0 = 0; done1 = 0;
    data0 = '0; data1 = '0;
    enb0 = 1; enb1 = 1; nme0 = 1; nale0 = 1; rnw0 = 1; noe0 = 1;
    nme1 = 1; nale1 = 1; rnw1 = 1; noe1 = 1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt0",  gnt0,  0);
    chk("rst_gnt1",  gnt1,  0);
    chk("rst_owner", owner, 1);
    chk("rst_busy",  busy,  0);
    chk("rst_tmo",   tmo,   0);
    chk_idle_bus("rst");

    // Single requester: one-cycle grant latency, non-owner inputs ignored.
    req0 = 1; nme1 = 0; data1 = 64'hBBBB_0000_1111_2222;
    tick();
    chk("g0_gnt0",  gnt0,  1);
    chk("g0_gnt1",  gnt1,  0);
    chk("g0_owner", owner, 0);
    chk("g0_busy",  busy,  1);
    chk("g0_nme_ign1", nme, 1);
    chk("g0_data_ign1", data, 64'd0);
    nme0 = 0; rnw0 = 0; data0 = 64'hAAAA_5555_DEAD_BEEF;
    #1;
    chk("g0_nme",  nme,  0);
    chk("g0_rnw",  rnw,  0);
    chk("g0_data", data, 64'hAAAA_5555_DEAD_BEEF);

    // Done and Req drop together: one release, bus idle in TURN even if core still drives.
    done0 = 1; req0 = 0;
    tick();
    chk("rel_gnt0", gnt0, 0);
    chk("rel_busy", busy, 0);
    chk_idle_bus("turn0");
    done0 = 0; nme0 = 1; rnw0 = 1; data0 = '0; nme1 = 1;
    tick();
    chk("idle_gnt0",  gnt0,  0);
    chk("idle_gnt1",  gnt1,  0);
    chk("idle_owner", owner, 0);

    // Simultaneous requests after reset: core 0 first, then alternate.
    rst = 1;
    tick();
    rst = 0;
    req0 = 1; req1 = 1;
    tick();
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1", gnt1, 0);
    enb0 = 0; done0 = 1; req0 = 0;
    tick();
    chk("tie_turn_gnt0", gnt0, 0);
    chk("tie_turn_gnt1", gnt1, 0);
    chk("tie_turn_enb",  enb,  1);
    chk("tie_turn_nme",  nme,  1);
    done0 = 0; enb0 = 1;
    tick();
    chk("alt_gnt1",  gnt1,  1);
    chk("alt_owner", owner, 1);
    chk("alt_data1", data,  64'hBBBB_0000_1111_2222);
    req0 = 1; done1 = 1;
    tick();
    chk("alt_turn_gnt1", gnt1, 0);
    chk("alt_turn_gnt0", gnt0, 0);
    done1 = 0;
    tick();
    chk("alt2_gnt0",  gnt0,  1);
    chk("alt2_owner", owner, 0);

    // Hand back to core 1 while core 0 keeps requesting, then test Lock.
    done0 = 1; req0 = 0;
    tick();
    done0 = 0; req0 = 1;
    tick();
    chk("lk_gnt1", gnt1, 1);
    lock1 = 1;
    for (int i = 0; i < 3; i++) begin
      done1 = 1;
      tick();
      done1 = 0;
      chk("lk_held_a", gnt1, 1);
      tick();
      chk("lk_held_b", gnt1, 1);
    end
    chk("lk_tmo", tmo, 0);
    lock1 = 0; done1 = 1;
    tick();
    chk("lk_rel_gnt1", gnt1, 0);
    chk("lk_rel_gnt0", gnt0, 0);
    done1 = 0;
    tick();
    chk("lk_next_gnt0", gnt0, 1);

    // Reset while core 1 owns the bus under Lock.
    req0 = 0;
    tick();
    tick();
    chk("mr_gnt1",  gnt1,  1);
    chk("mr_owner", owner, 1);
    lock1 = 1; nme1 = 0; nale1 = 0; noe1 = 0; enb1 = 0; rnw1 = 0;
    #1;
    chk("mr_nme_drv", nme, 0);
    rst = 1;
    tick();
    chk("mr_gnt1_after",  gnt1,  0);
    chk("mr_busy_after",  busy,  0);
    chk("mr_owner_after", owner, 1);
    chk_idle_bus("mr");
    nme1 = 1; nale1 = 1; noe1 = 1; enb1 = 1; rnw1 = 1;

    // Core 1 holds the bus locked while core 0 waits.
    rst = 0; req1 = 1; lock1 = 1; req0 = 0;
    tick();
    chk("wd_gnt1_main", gnt1,   1);
    chk("wd_gnt1_b",    gnt1_b, 1);
    req0 = 1;
    n_held = 1;
    tmo_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tmo_b) tmo_seen = 1'b1;
      if (!gnt1_b) break;
      n_held++;
    end
    chk("wd_main_still_held", gnt1, 1);
`ifdef ARB_WATCHDOG_EN
    chk("wd_grant_cycles", n_held, 4);
    chk("wd_tmo_in_turn",  tmo_b,  1);
    chk("wd_turn_gnt0",    gnt0_b, 0);
    tick();
    chk("wd_next_gnt0", gnt0_b, 1);
    chk("wd_tmo_clear", tmo_b,  0);
`else
    chk("nowd_grant_cycles", n_held,   31);
    chk("nowd_tmo_seen",     tmo_seen, 0);
    chk("nowd_tmo_main",     tmo,      0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_core_bus_arbiter.md
# dual_core_bus_arbiter

Two-requester arbiter placed between the two CPU cores of the dual-core design and a single shared external memory bus. Each core keeps its native bus signal set (data, ENB, nME, nALE, RnW, nOE). The arbiter grants ownership to one core at a time, fairly. It routes the owner's bus signals to the shared bus and drives inactive (idle) bus levels whenever no core owns the bus, including a mandatory one-cycle turnaround between owners.

## Interface
- DATA_W, 64, width of data path
- TIMEOUT, 255, max grant cycles before forced release (only with watchdog); 1..255
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Req0, Req1  in  1  bus request from core 0 / core 1
- Lock0, Lock1  in  1  hold bus across Done (atomic sequence)
- Done0, Done1  in  1  one-cycle pulse: owner finished a transfer
- Gnt0, Gnt1  out  1  registered grant; at most one high
- Data_out0, Data_out1  in  DATA_W  core write data
- ENB0, ENB1  in  1  core data-driver enable, active low
- nME0, nALE0, RnW0, nOE0 / nME1, nALE1, RnW1, nOE1  in  1  core bus controls
- Data_out  out  DATA_W  shared bus write data
- ENB, nME, nALE, RnW, nOE  out  1  shared bus controls
- Owner  out  1  last/current owner index
- Busy  out  1  a grant is active
- Timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, OWN0, OWN1, TURN.
- Reset: state IDLE, Gnt0=Gnt1=0, Owner=1 (so core 0 wins the first tie), Busy=0, Timeout=0, grant counter 0.
- IDLE/TURN arbitration (next-state):
  - only Req0 -> OWN0
  - only Req1 -> OWN1
  - both -> OWN of the core ≠ Owner (round-robin)
  - none -> IDLE
- TURN always lasts exactly one cycle; it arbitrates like IDLE.
- OWNx release condition: (Donex & ~Lockx) | ~Reqx -> TURN. Otherwise stay.
  - Donex while Lockx=1 is ignored.
  - Requests from the other core never pre-empt, except by the watchdog.
- On entry to OWNx: Owner<=x, Busy<=1, counter<=0. Leaving OWNx clears Busy.
- Bus mux:
  - In OWNx, the shared outputs equal core x's inputs combinationally: Data_out, ENB, nME, nALE, RnW, nOE.
  - In IDLE/TURN, outputs take idle values: ENB=1, nME=1, nALE=1, RnW=1, nOE=1, Data_out=0.
  - Non-owner inputs never reach the bus.
- Gnt0/Gnt1 are decoded from the registered state: high only in OWN0/OWN1.
- Reset mid-grant: the next edge forces IDLE, idle bus levels and clears grants, regardless of Lock.

## Timing
- Grant latency: Req sampled at edge k from IDLE -> Gnt high after edge k (1 cycle). From TURN, the same.
- Release: condition true at edge k -> TURN after k, Gnt low. Next grant after edge k+1. Minimum owner-to-owner gap is 1 idle bus cycle.
- Simultaneous Req0/Req1 rising in IDLE: the non-Owner core wins. The loser's Req must stay high; it is served next.
- Done and Req drop in the same cycle: a single release, no double transition.
- Core reaction: a core may drive bus cycles starting the cycle after it sees its Gnt high. It must finish with its signals at idle levels before asserting Done.

## Configuration
- ARB_WATCHDOG_EN defined:
  - An 8-bit counter increments each OWNx cycle.
  - If counter==TIMEOUT-1 and the other core's Req is high, force -> TURN, and Timeout pulses for 1 cycle, aligned with TURN.
  - Lock does not block a forced release.
  - Counter saturates when there is no other request.
- Undefined: no counter, Timeout tied 0, release only via Done/Req.

## Test plan
- Reset, then Req0=1 -> Gnt0=1 one cycle later, Owner=0, nME follows nME0; nME1=0 has no effect on nME.
- Req0 and Req1 asserted in the same cycle after reset -> Gnt0 first. After Done0 -> one TURN cycle with nME=1/ENB=1 -> Gnt1. Repeat both -> Gnt0 (alternation).
- Lock1=1, Done1 pulsed 3 times while Req0=1 -> Gnt1 held. Lock1=0 with Done1 -> TURN -> Gnt0.
- Reset asserted during OWN1 with Lock1=1 -> after the next edge Gnt1=0, all bus controls 1, Data_out=0, Owner=1.
- ARB_WATCHDOG_EN, TIMEOUT=4: Req1 held, Lock1=1, Req0 raised -> Gnt1 for 4 cycles, Timeout=1 in TURN, then Gnt0.
- Without the macro, the same stimulus -> Gnt1 held indefinitely, Timeout stays 0.
